// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, clock out one
// command byte on device clock edges, then collect the device ACK.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_drive_low,
    output logic       ps2_data_drive_low
);

    localparam int unsigned INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int unsigned TO_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [INH_W-1:0] INH_LOAD = INH_W'(INHIBIT_CYCLES - 1);
    // Reload is two short so the abort pulse lands TIMEOUT_CYCLES after the fe cycle.
    localparam logic [TO_W-1:0]  TO_LOAD  = TO_W'(TIMEOUT_CYCLES - 2);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_REQ,
        ST_SHIFT,
        ST_ACK,
        ST_WAIT_IDLE
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       clk_sync_q, clk_sync_d;
    logic [1:0]       data_sync_q, data_sync_d;
    logic             clk_prev_q, clk_prev_d;
    logic [9:0]       frame_q, frame_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic             ack_q, ack_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             clk_low_q, clk_low_d;
    logic             data_low_q, data_low_d;

    logic clk_s_c;
    logic data_s_c;
    logic fe_c;
    logic in_frame_c;
    logic timeout_c;

    assign clk_s_c    = clk_sync_q[1];
    assign data_s_c   = data_sync_q[1];
    assign fe_c       = clk_prev_q & ~clk_s_c;
    assign in_frame_c = (state_q == ST_SHIFT) || (state_q == ST_ACK) || (state_q == ST_WAIT_IDLE);
    assign timeout_c  = in_frame_c && (to_cnt_q == '0) && !fe_c;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (tx_start) begin
                    state_d = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                if (inh_cnt_q == '0) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (fe_c && (bit_cnt_q == 4'd9)) begin
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                if (fe_c) begin
                    state_d = ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                if (clk_s_c && data_s_c) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (timeout_c) begin
            state_d = ST_IDLE;
        end
    end

    // Output and datapath next values; pad drives and pulses are registered
    always_comb begin
        clk_sync_d  = {clk_sync_q[0], ps2_clk_in};
        data_sync_d = {data_sync_q[0], ps2_data_in};
        clk_prev_d  = clk_s_c;
        frame_d     = frame_q;
        bit_cnt_d   = bit_cnt_q;
        inh_cnt_d   = inh_cnt_q;
        to_cnt_d    = to_cnt_q;
        ack_d       = ack_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        clk_low_d   = clk_low_q;
        data_low_d  = data_low_q;

        if (in_frame_c) begin
            if (fe_c) begin
                to_cnt_d = TO_LOAD;
            end else if (to_cnt_q != '0) begin
                to_cnt_d = to_cnt_q - 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                busy_d     = 1'b0;
                clk_low_d  = 1'b0;
                data_low_d = 1'b0;
                if (tx_start) begin
                    frame_d   = {1'b1, ~^tx_data, tx_data};
                    bit_cnt_d = '0;
                    inh_cnt_d = INH_LOAD;
                    busy_d    = 1'b1;
                    clk_low_d = 1'b1;
                end
            end
            ST_INHIBIT: begin
                clk_low_d = 1'b1;
                if (inh_cnt_q == '0) begin
                    data_low_d = 1'b1;
                end else begin
                    inh_cnt_d = inh_cnt_q - 1'b1;
                end
            end
            ST_REQ: begin
                clk_low_d  = 1'b0;
                data_low_d = 1'b1;
                bit_cnt_d  = '0;
                to_cnt_d   = TO_LOAD;
            end
            ST_SHIFT: begin
                if (fe_c) begin
                    data_low_d = ~frame_q[bit_cnt_q];
                    bit_cnt_d  = bit_cnt_q + 1'b1;
                end
            end
            ST_ACK: begin
                if (fe_c) begin
                    ack_d = ~data_s_c;
                end
            end
            ST_WAIT_IDLE: begin
                if (clk_s_c && data_s_c) begin
                    busy_d = 1'b0;
                    done_d = ack_q;
                    err_d  = ~ack_q;
                end
            end
            default: begin
                busy_d     = 1'b0;
                clk_low_d  = 1'b0;
                data_low_d = 1'b0;
            end
        endcase

        if (timeout_c) begin
            busy_d     = 1'b0;
            clk_low_d  = 1'b0;
            data_low_d = 1'b0;
            done_d     = 1'b0;
            err_d      = 1'b1;
        end
    end

    // Datapath and output registers; synchronisers reset to the idle-high line level
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_prev_q  <= 1'b1;
            frame_q     <= '0;
            bit_cnt_q   <= '0;
            inh_cnt_q   <= '0;
            to_cnt_q    <= '0;
            ack_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            clk_low_q   <= 1'b0;
            data_low_q  <= 1'b0;
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            clk_prev_q  <= clk_prev_d;
            frame_q     <= frame_d;
            bit_cnt_q   <= bit_cnt_d;
            inh_cnt_q   <= inh_cnt_d;
            to_cnt_q    <= to_cnt_d;
            ack_q       <= ack_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            clk_low_q   <= clk_low_d;
            data_low_q  <= data_low_d;
        end
    end

    assign tx_busy            = busy_q;
    assign tx_done            = done_q;
    assign tx_error           = err_q;
    assign ps2_clk_drive_low  = clk_low_q;
    assign ps2_data_drive_low = data_low_q;

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
Host-to-device PS/2 transmitter. It sends one command byte (for example 0xED set-LEDs, 0xF4 enable, 0xFF reset) to the keyboard over the open-collector PS/2 clock and data lines. It is the outbound counterpart of the scancode receive and decode path. It is driven by the keyboard control logic and shares the PS/2 pads with the receiver, which must ignore line activity while tx_busy=1.

Parameters:
INHIBIT_CYCLES, 5000, clk cycles the host holds PS/2 clock low before the request (100 µs at 50 MHz)
TIMEOUT_CYCLES, 1000000, max clk cycles between successive device clock falling edges before abort (20 ms at 50 MHz)

Ports:
clk  in  1  system clock (single clock domain)
reset_n  in  1  asynchronous active-low reset
tx_data  in  8  command byte, sampled on the accepted tx_start
tx_start  in  1  single-cycle request; ignored unless idle
tx_busy  out  1  high from the accepted start until completion or abort
tx_done  out  1  1-cycle pulse: frame sent and device ACK received
tx_error  out  1  1-cycle pulse: NACK or timeout
ps2_clk_in  in  1  raw PS/2 clock pad level (asynchronous)
ps2_data_in  in  1  raw PS/2 data pad level (asynchronous)
ps2_clk_drive_low  out  1  1 = pull PS/2 clock low, 0 = release (pad is high-Z)
ps2_data_drive_low  out  1  1 = pull PS/2 data low, 0 = release

Behaviour:
- Reset (asynchronous, reset_n=0): state IDLE. All outputs 0, so both lines are released. Counters and bit index are cleared. Reset mid-frame releases the lines immediately; no done or error pulse is issued.
- Synchronisation: ps2_clk_in and ps2_data_in each pass through a 2-flop synchroniser. A device falling edge (fe) is a 1-cycle pulse when synced clock prev=1 and cur=0.
- Frame: start 0, D0..D7 LSB first, odd parity (~^tx_data), stop 1, then device ACK.
- IDLE: on tx_start=1, latch tx_data and parity, set tx_busy=1 next cycle, go to INHIBIT.
- INHIBIT: clk_drive_low=1 and data_drive_low=0 for exactly INHIBIT_CYCLES cycles, then go to REQ.
- REQ: clk_drive_low=1 and data_drive_low=1 (start bit) for 1 cycle. Next cycle release the clock (clk_drive_low=0), keep data low, clear bit index, load the timeout counter, go to SHIFT.
- SHIFT: on the k-th fe (k=1..10), drive frame bit k. Bits 1..8 are D0..D7, bit 9 is parity, bit 10 is stop. The bit is applied as data_drive_low = ~bit, updated the cycle after fe. After the 10th fe (stop, line released), go to ACK.
- ACK: on the next fe (the 11th), sample synced data. If 0, record ACK; if 1, record NACK. Go to WAIT_IDLE.
- WAIT_IDLE: wait until synced clock=1 and synced data=1. Then pulse tx_done (ACK) or tx_error (NACK), clear tx_busy in the same cycle, and go to IDLE.
- Timeout: in SHIFT, ACK and WAIT_IDLE the counter reloads on every fe and decrements otherwise. At 0: release both lines, pulse tx_error, clear tx_busy, go to IDLE.
- tx_start while tx_busy=1 is ignored; the latched byte is unchanged.
- fe pulses seen in IDLE, INHIBIT or REQ are ignored.
- tx_done and tx_error are never asserted in the same cycle.
- Minimum accepted-start to done latency: INHIBIT_CYCLES + 1 + (11 device clock periods) + synchroniser delay.

Test Plan:
- Send 0xED with a device model at a 12.5 kHz clock that ACKs -> lines observed D0..D7 = 1,0,1,1,0,1,1,1, parity=1, stop released; tx_done pulses once; tx_busy falls in the same cycle; tx_error stays 0.
- Send 0x00 -> parity bit=1; send 0xFF -> parity bit=1; send 0x01 -> parity bit=0; all complete with tx_done.
- Check the request phase -> clk_drive_low high for exactly INHIBIT_CYCLES cycles, then 1 cycle with both lines low, then the clock is released with data still low.
- Device leaves data high at the 11th fe (NACK) -> tx_error pulses once, tx_done stays 0, both lines released, tx_busy=0.
- Device stops clocking after bit 4 -> tx_error pulses exactly TIMEOUT_CYCLES cycles after the last fe; both lines released.
- tx_start pulsed while busy with 0x55 -> ignored, original byte transmitted. reset_n pulsed low mid-SHIFT -> both drive_low outputs 0 immediately; no done or error pulse; a new tx_start after reset completes normally.
